// File: rtl/ps2_rx_front.sv
// ps2_rx_front
// Serial front end for a PS/2 device. Synchronises the raw clock and data
// pins, deglitches the clock, detects falling edges and frames each 11-bit
// packet (start, 8 data bits LSB-first, odd parity, stop).
//
// Ports:
//   CLOCK_50    system clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_dat     raw PS/2 data pin (asynchronous)
//   enable      one-cycle shift strobe per received frame bit
//   inBit       sampled bit, valid while enable=1
//   frame_done  one-cycle pulse at the end of every frame
//   frame_err   0 ok, 1 parity, 2 stop, 3 timeout (valid with frame_done)
//   data_out    last good byte, held until the next good frame
//   busy        high while a frame is being received
module ps2_rx_front #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       enable,
    output logic       inBit,
    output logic       frame_done,
    output logic [1:0] frame_err,
    output logic [7:0] data_out,
    output logic       busy
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    // Odd parity holds when data plus parity carries an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Parity error outranks stop error.
    function automatic logic [1:0] frame_code(input logic [7:0] d, input logic p,
                                              input logic s);
        if (!parity_ok(d, p))
            return 2'd1;
        else if (!s)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_p0;
    logic [SYNC_STAGES-1:0] dat_sync_p0;
    logic                   clk_s;
    logic                   dat_s;

    logic          fclk_p1;
    logic [FW-1:0] fcnt_p1;
    logic          fall_p2;
    logic          samp_p2;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tcnt;
    logic [7:0]    shbuf_p3;
    logic          par_p3;
    logic          stop_p3;

    // ---- stage 0: pin synchronisers (idle-high lines reset to 1)
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_p0 <= '1;
            dat_sync_p0 <= '1;
        end else begin
            clk_sync_p0 <= {clk_sync_p0[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_p0 <= {dat_sync_p0[SYNC_STAGES-2:0], ps2_dat};
        end
    end

    assign clk_s = clk_sync_p0[SYNC_STAGES-1];
    assign dat_s = dat_sync_p0[SYNC_STAGES-1];

    // ---- stage 1/2: clock filter and falling-edge capture
    // The filtered clock flips only after FILTER_LEN consecutive samples that
    // disagree with it; a shorter run resets the count. Data is captured in
    // the same cycle the filtered clock falls.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            fclk_p1 <= 1'b1;
            fcnt_p1 <= '0;
            fall_p2 <= 1'b0;
            samp_p2 <= 1'b1;
        end else begin
            fall_p2 <= 1'b0;
            if (clk_s != fclk_p1) begin
                if (fcnt_p1 == FW'(FILTER_LEN - 1)) begin
                    fclk_p1 <= clk_s;
                    fcnt_p1 <= '0;
                    if (!clk_s) begin
                        fall_p2 <= 1'b1;
                        samp_p2 <= dat_s;
                    end
                end else begin
                    fcnt_p1 <= fcnt_p1 + FW'(1);
                end
            end else begin
                fcnt_p1 <= '0;
            end
        end
    end

    // ---- stage 3: frame payload capture
    // Fully overwritten by every complete frame, so a reset needs no clear.
    always_ff @(posedge CLOCK_50) begin
        if (state == RECV && fall_p2) begin
            if (bit_cnt <= 4'd8)
                shbuf_p3 <= {samp_p2, shbuf_p3[7:1]};
            if (bit_cnt == 4'd9)
                par_p3 <= samp_p2;
            if (bit_cnt == 4'd10)
                stop_p3 <= samp_p2;
        end
    end

    // ---- stage 3: framing FSM with registered outputs
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            tcnt       <= '0;
            enable     <= 1'b0;
            inBit      <= 1'b1;
            frame_done <= 1'b0;
            frame_err  <= 2'd0;
            data_out   <= 8'h00;
            busy       <= 1'b0;
        end else begin
            enable     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    // Only a low start bit opens a frame; idle-high edges are ignored.
                    if (fall_p2 && !samp_p2) begin
                        enable  <= 1'b1;
                        inBit   <= 1'b0;
                        bit_cnt <= 4'd1;
                        busy    <= 1'b1;
                        state   <= RECV;
                    end
                end
                RECV: begin
                    if (fall_p2) begin
                        enable  <= 1'b1;
                        inBit   <= samp_p2;
                        tcnt    <= '0;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd10)
                            state <= DONE;
                    end else if (tcnt >= TW'(TIMEOUT_CYCLES - 1)) begin
                        frame_done <= 1'b1;
                        frame_err  <= 2'd3;
                        busy       <= 1'b0;
                        bit_cnt    <= '0;
                        tcnt       <= '0;
                        state      <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    frame_err  <= frame_code(shbuf_p3, par_p3, stop_p3);
                    if (frame_code(shbuf_p3, par_p3, stop_p3) == 2'd0)
                        data_out <= shbuf_p3;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_front.sv
// tb_ps2_rx_front
// Randomised scoreboard bench for ps2_rx_front. Stimulus tasks push the
// expected strobe bits and frame outcomes into queues; a monitor process
// pops and compares them whenever the DUT strobes enable or frame_done.
module tb_ps2_rx_front;

    localparam int TIMEOUT = 5000;
    localparam int HALF    = 25;   // PS/2 clock half period in system cycles

    logic       CLOCK_50 = 1'b0;
    logic       reset_n  = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_dat  = 1'b1;
    logic       enable;
    logic       inBit;
    logic       frame_done;
    logic [1:0] frame_err;
    logic [7:0] data_out;
    logic       busy;

    ps2_rx_front #(
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .enable    (enable),
        .inBit     (inBit),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [1:0] err;
        logic [7:0] data;
        bit         to;
    } res_t;

    logic       exp_bits[$];
    res_t       exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_en = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference outcome of a complete frame from its byte, parity and stop bit.
    function automatic logic [1:0] model_err(input logic [7:0] b, input logic p,
                                             input logic s);
        int ones;
        ones = $countones(b) + int'(p);
        if (ones % 2 == 0) return 2'd1;
        if (!s) return 2'd2;
        return 2'd0;
    endfunction

    // Monitor
    always @(negedge CLOCK_50) begin
        if (reset_n) begin
            if (enable) begin
                if (exp_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_enable: got enable=1 inBit=%0d expected no strobe", inBit);
                end else begin
                    chk("inBit", int'(inBit), int'(exp_bits.pop_front()));
                    chk("busy_during_bit", int'(busy), 1);
                end
                last_en = cyc;
            end
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: got err=%0d expected no frame", frame_err);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("frame_err", int'(frame_err), int'(r.err));
                    chk("data_out", int'(data_out), int'(r.data));
                    chk("busy_after_frame", int'(busy), 0);
                    if (r.to) begin
                        checks++;
                        if (cyc - last_en < TIMEOUT - 2 || cyc - last_en > TIMEOUT + 2) begin
                            errors++;
                            $display("FAIL timeout_gap: got %0d cycles required %0d", cyc - last_en, TIMEOUT);
                        end
                    end
                end
            end
        end
    end

    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_dat = b;
        repeat (HALF / 2) @(posedge CLOCK_50);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (2) @(posedge CLOCK_50);
            ps2_clk = 1'b1;
            repeat (4) @(posedge CLOCK_50);
        end
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge CLOCK_50);
        ps2_clk = 1'b1;
        repeat (HALF / 2) @(posedge CLOCK_50);
    endtask

    // Sends the first nbits of a frame; a full frame also queues its outcome.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input int nbits, input int glitch_at);
        logic [10:0] fr;
        res_t r;
        fr = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) exp_bits.push_back(fr[i]);
        if (nbits == 11) begin
            r.err = model_err(b, par, stp);
            if (r.err == 2'd0) last_good = b;
            r.data = last_good;
            r.to   = 1'b0;
            exp_q.push_back(r);
        end
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i], i == glitch_at);
        ps2_dat = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_enable"}, int'(enable), 0);
        chk({tag, "_inBit"}, int'(inBit), 1);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
        chk({tag, "_data_out"}, int'(data_out), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #1800000;
        $display("FAIL watchdog: got no completion expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       p;
        logic       s;
        res_t       r;

        #2 reset_n = 1'b0;
        #3 check_reset_outputs("reset");
        repeat (5) @(posedge CLOCK_50);
        #3 reset_n = 1'b1;
        repeat (10) @(posedge CLOCK_50);

        // Idle-high edges must not strobe.
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);

        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
        send_frame(8'hF0, 1'b1, 1'b0, 11, -1);

        // Clock stalls after five data bits.
        r.err = 2'd3;
        r.data = last_good;
        r.to = 1'b1;
        exp_q.push_back(r);
        send_frame(8'hA5, 1'b1, 1'b1, 6, -1);
        repeat (6000) @(posedge CLOCK_50);

        send_frame(8'h5A, 1'b1, 1'b1, 11, -1);

        // Short glitches in idle and mid-frame.
        ps2_clk = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        ps2_clk = 1'b1;
        repeat (20) @(posedge CLOCK_50);
        send_frame(8'h5A, 1'b1, 1'b1, 11, 4);

        // Reset mid-frame after data bit 6.
        send_frame(8'h3C, 1'b1, 1'b1, 8, -1);
        chk("partial_bits_seen", exp_bits.size(), 0);
        @(posedge CLOCK_50);
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        last_good = 8'h00;
        repeat (5) @(posedge CLOCK_50);
        #3 reset_n = 1'b1;
        repeat (10) @(posedge CLOCK_50);

        send_frame(8'h29, 1'b0, 1'b1, 11, -1);

        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            p = (~^b) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 3) != 0);
            send_frame(b, p, s, 11, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
        end

        for (int i = 0; i < 200 && (exp_bits.size() > 0 || exp_q.size() > 0); i++)
            @(posedge CLOCK_50);
        chk("bits_left", exp_bits.size(), 0);
        chk("frames_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
